// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
//
// Run / stop / single-step controller for the CPU core on the Nexys-4 test
// top. It turns two raw board buttons into clean press pulses and produces a
// registered one-cycle clock enable (cpu_en) for the core from the single
// system clock. This lets the core run continuously at a selectable rate,
// stop, or step in bursts of N enables. A level halt request from the core,
// such as a breakpoint, always forces a stop.
//
// Parameters
//   DEB_CYCLES  consecutive stable cycles before a button level change is
//               accepted (1..65535). Honoured only when debouncing is built.
//
// Build option
//   RUN_CTRL_DEBOUNCE_EN
//     Defined:   each button has a debounce counter of DEB_CYCLES cycles.
//     Undefined: the debounced level is the synchronizer output itself, with
//                no counters, and DEB_CYCLES is ignored.
//
// Ports
//   clk         in   system clock; all logic runs on the rising edge
//   reset       in   synchronous, active-high reset
//   btn_run     in   raw run/stop toggle button (asynchronous)
//   btn_step    in   raw step button (asynchronous)
//   halt_req    in   synchronous stop request from the core (level)
//   speed_sel   in   [3:0] run rate select, enable period P = 2^speed_sel
//   step_n      in   [7:0] enables per step press (0 is treated as 1)
//   cpu_en      out  registered one-cycle clock enable to the core
//   running     out  high while the controller is in RUN
//   state       out  [1:0] 0 = STOP, 1 = RUN, 2 = STEP
//   steps_left  out  [7:0] enables remaining in the current burst
//   cycle_cnt   out  [31:0] total enables issued (wraps to 0)
// ---------------------------------------------------------------------------
module run_ctrl #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        halt_req,
  input  logic [3:0]  speed_sel,
  input  logic [7:0]  step_n,
  output logic        cpu_en,
  output logic        running,
  output logic [1:0]  state,
  output logic [7:0]  steps_left,
  output logic [31:0] cycle_cnt
);

  // -------------------------------------------------------------------------
  // State encoding (kept as plain constants so the numeric value appears
  // directly on the state output)
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  // Bit positions of the two buttons inside the packed button vectors.
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  // -------------------------------------------------------------------------
  // Button path: 2-FF synchronizer, debounced level, rising-edge press
  // -------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] sync1_q;  // first synchronizer stage (may be metastable)
  logic [1:0] s2_q;     // second synchronizer stage, safe to use
  logic [1:0] deb;      // debounced level
  logic [1:0] deb_d_q;  // debounced level one cycle ago
  logic [1:0] press;    // one-cycle press pulse, combinational

  assign btn_raw = {btn_step, btn_run};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      s2_q    <= '0;
      deb_d_q <= '0;
    end else begin
      // NOTE: sequential state is always written with <= so every register
      // samples the pre-edge value of the others; with = the second stage
      // would copy the first stage's new value and collapse the synchronizer.
      sync1_q <= btn_raw;
      s2_q    <= sync1_q;
      deb_d_q <= deb;
    end
  end

`ifdef RUN_CTRL_DEBOUNCE_EN
  // A level change on s2 is accepted only after it has differed from the
  // accepted level for DEB_CYCLES consecutive cycles. Any bounce back to
  // the accepted level restarts the count.
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  logic [15:0] cnt_q [2];
  logic [1:0]  deb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this small counter array is control state, not storage, so it
      // is reset explicitly; a real RAM would be left unreset.
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      deb_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          deb_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign deb = deb_q;
`else
  // Debouncing disabled: the synchronizer output is taken as the clean level.
  logic unused_deb_cycles;
  assign unused_deb_cycles = ^DEB_CYCLES;
  assign deb = s2_q;
`endif

  // Only rising edges of the debounced level count as presses; releases
  // are deliberately ignored.
  assign press = deb & ~deb_d_q;

  logic run_press;
  logic step_press;
  assign run_press  = press[BTN_RUN];
  assign step_press = press[BTN_STEP];

  // -------------------------------------------------------------------------
  // Rate divider terminal
  // -------------------------------------------------------------------------
  // The terminal test is ">=" rather than "==" so that lowering speed_sel
  // while div is already past the new period still fires on the next edge
  // instead of running div all the way around its 16-bit range.
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic [16:0] period_m1;
  logic        div_term;

  assign period_m1 = (17'd1 << speed_sel) - 17'd1;
  assign div_term  = ({1'b0, div_q} >= period_m1);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        cpu_en_q;
  logic        cpu_en_d;
  logic [7:0]  steps_q;
  logic [7:0]  steps_d;
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;

  // Handles the divider and the enable it produces while RUN or STEP is
  // allowed to continue this cycle.
  logic tick_en;
  assign tick_en = div_term;

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    div_d    = div_q;
    cpu_en_d = 1'b0;
    steps_d  = steps_q;
    cycle_d  = cycle_q;

    unique case (state_q)
      ST_STOP: begin
        // halt_req outranks both buttons; a press seen while halted is
        // consumed and lost, not deferred.
        if (!halt_req) begin
          if (run_press) begin
            state_d = ST_RUN;
            div_d   = '0;
          end else if (step_press) begin
            state_d = ST_STEP;
            div_d   = '0;
            steps_d = (step_n == 8'd0) ? 8'd1 : step_n;
          end
        end
      end

      ST_RUN: begin
        // Leaving RUN suppresses any enable that would have been issued on
        // this same edge. Step presses are ignored while running.
        if (halt_req || run_press) begin
          state_d = ST_STOP;
        end else if (tick_en) begin
          div_d    = '0;
          cpu_en_d = 1'b1;
          cycle_d  = cycle_q + 32'd1;
        end else begin
          div_d = div_q + 16'd1;
        end
      end

      ST_STEP: begin
        if (halt_req || run_press) begin
          // Abort: the rest of the burst is discarded.
          state_d = ST_STOP;
          steps_d = '0;
        end else if (tick_en) begin
          div_d    = '0;
          cpu_en_d = 1'b1;
          cycle_d  = cycle_q + 32'd1;
          steps_d  = steps_q - 8'd1;
          // The last enable of the burst and the return to STOP share one
          // edge, so cpu_en is high in the first cycle that reads STOP.
          if (steps_q == 8'd1) begin
            state_d = ST_STOP;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end

      default: begin
        // Unused encoding: recover to a safe stop.
        state_d = ST_STOP;
        steps_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_STOP;
      div_q    <= '0;
      cpu_en_q <= 1'b0;
      steps_q  <= '0;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cpu_en_q <= cpu_en_d;
      steps_q  <= steps_d;
      cycle_q  <= cycle_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all taken straight from registers)
  // -------------------------------------------------------------------------
  assign cpu_en     = cpu_en_q;
  assign running    = (state_q == ST_RUN);
  assign state      = state_q;
  assign steps_left = steps_q;
  assign cycle_cnt  = cycle_q;

  // Alias so the cycle counter can be located by a conventional name.
  logic [31:0] cycle_cnt_q;
  assign cycle_cnt_q = cycle_q;

endmodule
